rect_raster: RTL and testbench

//   Parametrised rectangle rasteriser for the drawing pipeline. Takes two arbitrary corners and emits pixel coordinates:
//   - outline mode: every pixel of the rectangle's border, each exactly once;
//   - fill mode: every pixel of the rectangle, row by row.

---
 rtl/rect_pkg.sv | 26 ++
 rtl/rect_walker.sv | 65 ++++++
 rtl/rect_raster.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_rect_raster.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rect_pkg
// Description : Shared types and constants for the rectangle rasteriser.
// Revision    : 1.0 - initial release
// ============================================================================
package rect_pkg;

    // Rasteriser control states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_TOP    = 3'd2,
        ST_RIGHT  = 3'd3,
        ST_BOTTOM = 3'd4,
        ST_LEFT   = 3'd5,
        ST_FILL   = 3'd6,
        ST_FINISH = 3'd7
    } state_e;

    // Drawing modes, sampled together with start
    localparam logic MODE_OUTLINE = 1'b0;
    localparam logic MODE_FILL    = 1'b1;

endpackage : rect_pkg
`default_nettype wire

// File: rtl/rect_walker.sv
`default_nettype none
// ============================================================================
// Module      : rect_walker
// Description : Single-axis coordinate walker for one edge or one fill row.
//               Holds the current coordinate, the end coordinate and the
//               direction. Termination is by equality with the end value, so
//               the incremented/decremented value is never compared and a
//               wrap at 0 or full scale can never be observed.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_walker #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,        // start a new run
    input  logic [COORD_W-1:0] load_start,  // first coordinate of the run
    input  logic [COORD_W-1:0] load_end,    // last coordinate of the run
    input  logic               load_down,   // 1 = descending
    input  logic               adv,         // step to the next coordinate
    output logic [COORD_W-1:0] nxt,         // coordinate after the current one
    output logic               last         // current coordinate is the end
);

    localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

    logic [COORD_W-1:0] cur_q, cur_d;
    logic [COORD_W-1:0] end_q, end_d;
    logic               down_q, down_d;

    // Step value and termination flag derived from the held run state
    always_comb begin
        nxt  = down_q ? (cur_q - C_ONE) : (cur_q + C_ONE);
        last = (cur_q == end_q);
    end

    // Next-state: a load replaces the run, otherwise advance unless at the end
    always_comb begin
        cur_d  = cur_q;
        end_d  = end_q;
        down_d = down_q;
        if (load) begin
            cur_d  = load_start;
            end_d  = load_end;
            down_d = load_down;
        end else if (adv && !last) begin
            cur_d  = nxt;
        end
    end

    // Run state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            end_q  <= '0;
            down_q <= 1'b0;
        end else begin
            cur_q  <= cur_d;
            end_q  <= end_d;
            down_q <= down_d;
        end
    end

endmodule : rect_walker
`default_nettype wire

// File: rtl/rect_raster.sv
`default_nettype none
// ============================================================================
// Module      : rect_raster
// Description : Rectangle rasteriser. Sorts two corners, then emits either the
//               border (each pixel once, clockwise from the top-left) or every
//               pixel row by row, on a registered ready/valid stream. Supports
//               abort and counts accepted pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_raster
    import rect_pkg::*;
#(
    parameter int COORD_W = 8,
    parameter int CNT_W   = 2*COORD_W+1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pix_count
);

    localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
    localparam logic [COORD_W-1:0] C_TWO     = COORD_W'(2);
    localparam logic [CNT_W-1:0]   C_CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [COORD_W-1:0] ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
    logic [COORD_W-1:0] mnx_q, mnx_d, mxx_q, mxx_d, mny_q, mny_d, mxy_q, mxy_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic               pix_valid_q, pix_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [COORD_W-1:0] w_mnx, w_mxx, w_mny, w_mxy;
    logic               w_fire;
    logic               w_tall;

    logic               wk_load, wk_down, wk_adv, wk_last;
    logic [COORD_W-1:0] wk_start, wk_end, wk_nxt;

    rect_walker #(
        .COORD_W   (COORD_W)
    ) u_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (wk_load),
        .load_start (wk_start),
        .load_end   (wk_end),
        .load_down  (wk_down),
        .adv        (wk_adv),
        .nxt        (wk_nxt),
        .last       (wk_last)
    );

    // Corner sort, handshake and left-edge presence (needs at least 3 rows)
    always_comb begin
        w_mnx  = (ax_q < bx_q) ? ax_q : bx_q;
        w_mxx  = (ax_q < bx_q) ? bx_q : ax_q;
        w_mny  = (ay_q < by_q) ? ay_q : by_q;
        w_mxy  = (ay_q < by_q) ? by_q : ay_q;
        w_fire = pix_valid_q && pix_ready;
        w_tall = ((mxy_q - mny_q) >= C_TWO);
    end

    // FSM next-state, walker control and output register inputs
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ax_d        = ax_q;
        ay_d        = ay_q;
        bx_d        = bx_q;
        by_d        = by_q;
        mnx_d       = mnx_q;
        mxx_d       = mxx_q;
        mny_d       = mny_q;
        mxy_d       = mxy_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_valid_d = pix_valid_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        wk_load     = 1'b0;
        wk_start    = '0;
        wk_end      = '0;
        wk_down     = 1'b0;
        wk_adv      = 1'b0;

        // Every accepted pixel counts, including one taken alongside abort
        if (w_fire) begin
            cnt_d = cnt_q + C_CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                pix_valid_d = 1'b0;
                if (start) begin
                    ax_d    = x0;
                    ay_d    = y0;
                    bx_d    = x1;
                    by_d    = y1;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Top edge and first fill row share the same first run
                mnx_d       = w_mnx;
                mxx_d       = w_mxx;
                mny_d       = w_mny;
                mxy_d       = w_mxy;
                pix_x_d     = w_mnx;
                pix_y_d     = w_mxy;
                pix_valid_d = 1'b1;
                wk_load     = 1'b1;
                wk_start    = w_mnx;
                wk_end      = w_mxx;
                state_d     = (mode_q == MODE_FILL) ? ST_FILL : ST_TOP;
            end
            ST_TOP: begin
                if (w_fire) begin
                    if (!wk_last) begin
                        wk_adv  = 1'b1;
                        pix_x_d = wk_nxt;
                    end else if (mny_q != mxy_q) begin
                        pix_x_d  = mxx_q;
                        pix_y_d  = mxy_q - C_ONE;
                        wk_load  = 1'b1;
                        wk_start = mxy_q - C_ONE;
                        wk_end   = mny_q;
                        wk_down  = 1'b1;
                        state_d  = ST_RIGHT;
                    end else begin
                        pix_valid_d = 1'b0;
                        state_d     = ST_FINISH;
                    end
                end
            end
            ST_RIGHT: begin
                if (w_fire) begin
                    if (!wk_last) begin
                        wk_adv  = 1'b1;
                        pix_y_d = wk_nxt;
                    end else if (mnx_q != mxx_q) begin
                        pix_x_d  = mxx_q - C_ONE;
                        pix_y_d  = mny_q;
                        wk_load  = 1'b1;
                        wk_start = mxx_q - C_ONE;
                        wk_end   = mnx_q;
                        wk_down  = 1'b1;
                        state_d  = ST_BOTTOM;
                    end else begin
                        pix_valid_d = 1'b0;
                        state_d     = ST_FINISH;
                    end
                end
            end
            ST_BOTTOM: begin
                if (w_fire) begin
                    if (!wk_last) begin
                        wk_adv  = 1'b1;
                        pix_x_d = wk_nxt;
                    end else if (w_tall) begin
                        pix_x_d  = mnx_q;
                        pix_y_d  = mny_q + C_ONE;
                        wk_load  = 1'b1;
                        wk_start = mny_q + C_ONE;
                        wk_end   = mxy_q - C_ONE;
                        state_d  = ST_LEFT;
                    end else begin
                        pix_valid_d = 1'b0;
                        state_d     = ST_FINISH;
                    end
                end
            end
            ST_LEFT: begin
                if (w_fire) begin
                    if (!wk_last) begin
                        wk_adv  = 1'b1;
                        pix_y_d = wk_nxt;
                    end else begin
                        pix_valid_d = 1'b0;
                        state_d     = ST_FINISH;
                    end
                end
            end
            ST_FILL: begin
                if (w_fire) begin
                    if (!wk_last) begin
                        wk_adv  = 1'b1;
                        pix_x_d = wk_nxt;
                    end else if (pix_y_q != mny_q) begin
                        pix_x_d  = mnx_q;
                        pix_y_d  = pix_y_q - C_ONE;
                        wk_load  = 1'b1;
                        wk_start = mnx_q;
                        wk_end   = mxx_q;
                        state_d  = ST_FILL;
                    end else begin
                        pix_valid_d = 1'b0;
                        state_d     = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                pix_valid_d = 1'b0;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                pix_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Abort overrides any walking progress; the shape ends via FINISH
        if (abort && (state_q inside {ST_SETUP, ST_TOP, ST_RIGHT, ST_BOTTOM, ST_LEFT, ST_FILL})) begin
            pix_valid_d = 1'b0;
            wk_load     = 1'b0;
            wk_adv      = 1'b0;
            state_d     = ST_FINISH;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, shape and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_OUTLINE;
            ax_q        <= '0;
            ay_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            mnx_q       <= '0;
            mxx_q       <= '0;
            mny_q       <= '0;
            mxy_q       <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ax_q        <= ax_d;
            ay_q        <= ay_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            mnx_q       <= mnx_d;
            mxx_q       <= mxx_d;
            mny_q       <= mny_d;
            mxy_q       <= mxy_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_count = cnt_q;

endmodule : rect_raster
`default_nettype wire

// File: tb/tb_rect_raster.sv
`default_nettype none
// ============================================================================
// Module      : tb_rect_raster
// Description : Self-checking bench for rect_raster. A queue-based reference
//               lists the pixels each shape must produce; a negedge monitor
//               compares every presented pixel and its stall stability, and
//               directed tests pin the reference with literal sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_raster;

    localparam int W  = 8;
    localparam int CW = 2*W+1;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [W-1:0]  pix_x, pix_y;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic          busy, done;
    logic [CW-1:0] pix_count;

    rect_raster #(
        .COORD_W (W),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_hs_cyc = 0;
    int   exp_count = 0;
    pix_t exp_q[$];
    pix_t got_q[$];
    int   lit_x[$];
    int   lit_y[$];

    logic stalled_prev = 1'b0;
    logic abort_prev = 1'b0;
    pix_t held;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic pix_t mk(input int x, input int y);
        pix_t p;
        p.x = W'(x);
        p.y = W'(y);
        return p;
    endfunction

    // Reference pixel list built straight from the drawing rules
    function automatic void build_model(input logic m, input int ax, input int ay,
                                        input int bx, input int by);
        int mnx, mxx, mny, mxy;
        mnx = (ax < bx) ? ax : bx;
        mxx = (ax < bx) ? bx : ax;
        mny = (ay < by) ? ay : by;
        mxy = (ay < by) ? by : ay;
        exp_q.delete();
        if (m) begin
            for (int y = mxy; y >= mny; y--)
                for (int x = mnx; x <= mxx; x++) exp_q.push_back(mk(x, y));
        end else begin
            for (int x = mnx; x <= mxx; x++) exp_q.push_back(mk(x, mxy));
            for (int y = mxy - 1; y >= mny; y--) exp_q.push_back(mk(mxx, y));
            if (mny != mxy)
                for (int x = mxx - 1; x >= mnx; x--) exp_q.push_back(mk(x, mny));
            if (mnx != mxx)
                for (int y = mny + 1; y <= mxy - 1; y++) exp_q.push_back(mk(mnx, y));
        end
        exp_count = exp_q.size();
    endfunction

    task automatic check_lit(input string nm);
        check({nm, "_len"}, got_q.size(), lit_x.size());
        for (int i = 0; i < lit_x.size() && i < got_q.size(); i++) begin
            check({nm, "_x"}, 32'(got_q[i].x), lit_x[i]);
            check({nm, "_y"}, 32'(got_q[i].y), lit_y[i]);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: order, stall stability, no surplus pixels
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled_prev && !abort_prev) begin
                check("hold_valid", pix_valid, 1);
                check("hold_x", pix_x, held.x);
                check("hold_y", pix_y, held.y);
            end
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    check("surplus_pixel", 1, 0);
                end else begin
                    check("pix_x", pix_x, exp_q[0].x);
                    check("pix_y", pix_y, exp_q[0].y);
                end
                if (pix_ready) begin
                    got_q.push_back(mk(int'(pix_x), int'(pix_y)));
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    last_hs_cyc = cyc;
                end
            end
            stalled_prev = pix_valid && !pix_ready;
            abort_prev   = abort;
            held         = mk(int'(pix_x), int'(pix_y));
        end else begin
            stalled_prev = 1'b0;
            abort_prev   = 1'b0;
        end
    end

    // One complete shape; entered and left at #1 after a rising edge
    task automatic run_shape(input logic m, input int ax, input int ay, input int bx,
                             input int by, input bit rnd, input bit poke);
        int budget;
        bit seen_done;
        build_model(m, ax, ay, bx, by);
        got_q.delete();
        mode = m; x0 = W'(ax); y0 = W'(ay); x1 = W'(bx); y1 = W'(by);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_latency", busy, 1);
        check("valid_latency_early", pix_valid, 0);
        @(posedge clk); #1;
        check("valid_latency", pix_valid, 1);
        budget = 0;
        seen_done = 1'b0;
        while (!seen_done && budget < 5000) begin
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke && (budget == 2);
            if (poke && budget == 2) begin
                mode = ~m; x0 = 9; y0 = 9; x1 = 11; y1 = 12;
            end
            @(posedge clk); #1;
            start = 1'b0;
            budget++;
            if (done) seen_done = 1'b1;
        end
        if (!seen_done) check("done_timeout", 0, 1);
        check("done_timing", cyc - last_hs_cyc, 2);
        check("model_drained", exp_q.size(), 0);
        check("count", pix_count, exp_count);
        check("busy_at_done", busy, 0);
        check("valid_at_done", pix_valid, 0);
        pix_ready = 1'b1;
    endtask

    // Outline (0,0)-(3,3) aborted after three accepted pixels
    task automatic abort_shape(input logic ready_in_abort, input int exp_cnt);
        build_model(1'b0, 0, 0, 3, 3);
        mode = 1'b0; x0 = 0; y0 = 0; x1 = 3; y1 = 3;
        pix_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_count", pix_count, 3);
        abort = 1'b1;
        pix_ready = ready_in_abort;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid_low", pix_valid, 0);
        check("abort_no_early_done", done, 0);
        @(posedge clk); #1;
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_count", pix_count, exp_cnt);
        exp_q.delete();
        pix_ready = 1'b1;
        @(posedge clk); #1;
        check("done_single_cycle", done, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", pix_count, 0);
        check("rst_x", pix_x, 0);
        check("rst_y", pix_y, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: outline, corners in either order, and a point
        run_shape(1'b0, 2, 3, 5, 1, 1'b0, 1'b0);
        lit_x = '{2, 3, 4, 5, 5, 5, 4, 3, 2, 2};
        lit_y = '{3, 3, 3, 3, 2, 1, 1, 1, 1, 2};
        check_lit("t1_outline");
        check("t1_count", pix_count, 10);
        run_shape(1'b0, 5, 1, 2, 3, 1'b0, 1'b0);
        check_lit("t2_swapped");
        run_shape(1'b0, 4, 4, 4, 4, 1'b0, 1'b0);
        lit_x = '{4};
        lit_y = '{4};
        check_lit("t2_point");
        check("t2_point_count", pix_count, 1);

        // 3: degenerate lines
        run_shape(1'b0, 1, 2, 4, 2, 1'b0, 1'b0);
        lit_x = '{1, 2, 3, 4};
        lit_y = '{2, 2, 2, 2};
        check_lit("t3_hline");
        run_shape(1'b0, 7, 0, 7, 3, 1'b0, 1'b0);
        lit_x = '{7, 7, 7, 7};
        lit_y = '{3, 2, 1, 0};
        check_lit("t3_vline");

        // 4: fill, with a start pulse while busy that must be ignored
        run_shape(1'b1, 0, 0, 2, 1, 1'b0, 1'b1);
        lit_x = '{0, 1, 2, 0, 1, 2};
        lit_y = '{1, 1, 1, 0, 0, 0};
        check_lit("t4_fill");
        check("t4_fill_count", pix_count, 6);
        run_shape(1'b1, 253, 253, 255, 255, 1'b0, 1'b0);
        check("t4_edge_count", pix_count, 9);
        for (int i = 0; i < got_q.size(); i++) begin
            check("t4_no_wrap_x", 32'(got_q[i].x >= 8'd253), 1);
            check("t4_no_wrap_y", 32'(got_q[i].y >= 8'd253), 1);
        end

        // 5: random backpressure
        run_shape(1'b0, 0, 0, 3, 3, 1'b1, 1'b0);
        check("t5_count", pix_count, 12);
        run_shape(1'b1, 3, 6, 0, 4, 1'b1, 1'b0);
        check("t5_fill_count", pix_count, 12);
        @(posedge clk); #1;
        check("done_single_cycle", done, 0);

        // 6: abort, with and without a handshake in the abort cycle
        abort_shape(1'b0, 3);
        abort_shape(1'b1, 4);

        // 6: reset during a fill
        build_model(1'b1, 0, 0, 7, 7);
        mode = 1'b1; x0 = 0; y0 = 0; x1 = 7; y1 = 7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_count", pix_count, 0);
        check("mid_rst_x", pix_x, 0);
        check("mid_rst_y", pix_y, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_hold_done", done, 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end

        // Recovery after reset
        run_shape(1'b0, 6, 2, 3, 4, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rect_raster
`default_nettype wire
